// File: rtl/shape_processor_pkg.sv
// Shared types, field positions and legality rule
// for the multi-channel shape processor.
package shape_processor_pkg;

  typedef enum logic [1:0] {
    CIRCLE    = 2'd0,
    RECTANGLE = 2'd1,
    TRIANGLE  = 2'd2
  } shape_e;

  typedef enum logic [4:0] {
    NOP       = 5'd0,
    PERIMETER = 5'd1,
    AREA      = 5'd2,
    SCALE     = 5'd3
  } operation_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef struct packed {
    shape_e     shape;
    operation_e operation;
  } ctrl_t;

  localparam int START_BIT = 31;
  localparam int SHAPE_LSB = 16;
  localparam int OP_LSB    = 0;
  localparam int BUSY_BIT  = 31;
  localparam int DONE_BIT  = 30;
  localparam int ERR_BIT   = 29;

  function automatic logic is_legal(
    input logic [1:0] shape,
    input logic [4:0] operation
  );
    logic ok;
    ok = (shape != 2'd3)
      && (operation < 5'd4)
      && !((shape == TRIANGLE)
        && (operation == SCALE));
    return ok;
  endfunction

  function automatic logic [31:0] status_word(
    input logic  busy,
    input logic  done,
    input logic  err,
    input ctrl_t c
  );
    logic [31:0] w;
    w = '0;
    w[BUSY_BIT]       = busy;
    w[DONE_BIT]       = done;
    w[ERR_BIT]        = err;
    w[SHAPE_LSB +: 2] = c.shape;
    w[OP_LSB +: 5]    = c.operation;
    return w;
  endfunction

endpackage

// File: rtl/shape_processor_channel.sv
// One channel: control fields, busy sequencer
// and sticky done/err flags.
module shape_processor_channel
  import shape_processor_pkg::*;
#(
  parameter int OP_CYCLES = 3
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  start,
  input  logic  fault,
  input  logic  clear,
  input  ctrl_t wr_ctrl,
  output ctrl_t ctrl,
  output logic  busy,
  output logic  done,
  output logic  err
);

  localparam logic [7:0] LAST = 8'(OP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '{shape: CIRCLE, operation: NOP};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Read clears go first so same-cycle sets win.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    done_d  = done_q;
    err_d   = err_q;
    if (clear) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (fault) err_d = 1'b1;
    if (load) ctrl_d = wr_ctrl;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ctrl = ctrl_q;
  assign busy = (state_q == ST_BUSY);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: rtl/shape_processor_mc.sv
// Multi-channel shape control block: address
// decode, legality check, read register, error.
module shape_processor_mc
  import shape_processor_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int OP_CYCLES    = 3,
  localparam int AW =
    (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          write,
  input  logic [31:0]   write_data,
  input  logic          read,
  output logic [31:0]   read_data,
  output logic          error
);

  logic [NUM_CHANNELS-1:0] sel;
  logic [NUM_CHANNELS-1:0] busy_v;
  logic [NUM_CHANNELS-1:0] done_v;
  logic [NUM_CHANNELS-1:0] err_v;
  ctrl_t                   ctrl_v [NUM_CHANNELS];
  logic [31:0]             stat_v [NUM_CHANNELS];

  logic        wr_start;
  logic [1:0]  wr_shape;
  logic [4:0]  wr_op;
  ctrl_t       wr_ctrl;
  logic        hit;
  logic        busy_hit;
  logic        legal;
  logic        go;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign wr_start = write_data[START_BIT];
  assign wr_shape = write_data[SHAPE_LSB +: 2];
  assign wr_op    = write_data[OP_LSB +: 5];
  assign wr_ctrl  = '{
    shape:     shape_e'(wr_shape),
    operation: operation_e'(wr_op)
  };
  assign unused_bits = ^{
    write_data[30:18],
    write_data[15:5]
  };

  // Out-of-range addresses select nothing.
  assign hit      = |sel;
  assign busy_hit = |(sel & busy_v);
  assign legal    = hit
    && is_legal(wr_shape, wr_op)
    && !(wr_start && busy_hit);
  assign go       = wr_start && (wr_op != NOP);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign sel[i] = (addr == AW'(i));

    shape_processor_channel #(
      .OP_CYCLES(OP_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (write && sel[i] && legal),
      .start  (write && sel[i] && legal && go),
      .fault  (write && sel[i] && !legal),
      .clear  (read && sel[i]),
      .wr_ctrl(wr_ctrl),
      .ctrl   (ctrl_v[i]),
      .busy   (busy_v[i]),
      .done   (done_v[i]),
      .err    (err_v[i])
    );

    assign stat_v[i] = status_word(
      busy_v[i], done_v[i], err_v[i], ctrl_v[i]);
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (sel[i]) rd_word = stat_v[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= '0;
      error     <= 1'b0;
    end else begin
      error <= write && !legal;
      if (read) read_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_shape_processor_mc.sv
// Scoreboard bench for shape_processor_mc:
// reads queue expectations, drained one cycle later.
module tb_shape_processor_mc;

  localparam int NCH = 4;
  localparam int OPC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr = '0;
  logic        write = 1'b0;
  logic [31:0] write_data = '0;
  logic        read = 1'b0;
  logic [31:0] read_data;
  logic        error;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  shape_processor_mc #(
    .NUM_CHANNELS(NCH),
    .OP_CYCLES   (OPC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .write     (write),
    .write_data(write_data),
    .read      (read),
    .read_data (read_data),
    .error     (error)
  );

  task automatic cyc(
    input logic        w,
    input logic        r,
    input logic [1:0]  a,
    input logic [31:0] d,
    input logic [31:0] e,
    input string       tag
  );
    logic [31:0] x;
    write = w;
    read = r;
    addr = a;
    write_data = d;
    if (r) exp_q.push_back(e);
    @(negedge clk);
    if (r) begin
      x = exp_q.pop_front();
      total++;
      if (read_data !== x) begin
        bad++;
        $display("FAIL %s: read_data=%h want=%h",
          tag, read_data, x);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 2'd0, '0, '0, "idle");
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (read_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_rd: got=%h want=0", read_data);
    end
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL rst_err: got=%b want=0", error);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      cyc(1'b0, 1'b1, 2'(i), '0, 32'h0, "rst_ch");
      total++;
      if (error !== 1'b0) begin
        bad++;
        $display("FAIL rst_ch_err: got=%b want=0", error);
      end
    end
  endtask

  task automatic test_write;
    cyc(1'b1, 1'b0, 2'd1, 32'h0001_0002, '0, "wr");
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL wr_err: got=%b want=0", error);
    end
    cyc(1'b0, 1'b1, 2'd1, '0, 32'h0001_0002, "wr_ch1");
    cyc(1'b0, 1'b1, 2'd0, '0, 32'h0, "wr_ch0");
    cyc(1'b0, 1'b1, 2'd2, '0, 32'h0, "wr_ch2");
    cyc(1'b0, 1'b1, 2'd3, '0, 32'h0, "wr_ch3");
    cyc(1'b1, 1'b0, 2'd1, 32'h7F0D_FFE1, '0, "wr");
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL wr_ign_err: got=%b want=0", error);
    end
    cyc(1'b0, 1'b1, 2'd1, '0, 32'h0001_0001, "wr_ignored");
    cyc(1'b1, 1'b1, 2'd0, 32'h0002_0002, 32'h0,
      "wr_same_cyc");
    cyc(1'b0, 1'b1, 2'd0, '0, 32'h0002_0002, "wr_next");
    cyc(1'b1, 1'b0, 2'd1, 32'h8002_0000, '0, "wr");
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL wr_nop_err: got=%b want=0", error);
    end
    cyc(1'b0, 1'b1, 2'd1, '0, 32'h0002_0000,
      "wr_start_nop");
  endtask

  task automatic test_illegal;
    cyc(1'b1, 1'b0, 2'd2, 32'h0002_0003, '0, "ill");
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL ill_pair: got=%b want=1", error);
    end
    idle(1);
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL ill_pulse: got=%b want=0", error);
    end
    cyc(1'b0, 1'b1, 2'd2, '0, 32'h2000_0000, "ill_rd1");
    cyc(1'b0, 1'b1, 2'd2, '0, 32'h0, "ill_rd2");
    cyc(1'b1, 1'b0, 2'd2, 32'h0003_0001, '0, "ill");
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL ill_shape: got=%b want=1", error);
    end
    cyc(1'b1, 1'b0, 2'd2, 32'h0001_0004, '0, "ill");
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL ill_op: got=%b want=1", error);
    end
    cyc(1'b1, 1'b0, 2'd2, 32'h0001_0003, '0, "ill");
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL ill_legal: got=%b want=0", error);
    end
    cyc(1'b0, 1'b1, 2'd2, '0, 32'h2001_0003, "ill_sticky");
    cyc(1'b0, 1'b1, 2'd2, '0, 32'h0001_0003, "ill_clr");
  endtask

  task automatic test_busy;
    cyc(1'b1, 1'b0, 2'd0, 32'h8000_0001, '0, "bsy");
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL bsy_start: got=%b want=0", error);
    end
    for (int i = 0; i < OPC; i++)
      cyc(1'b0, 1'b1, 2'd0, '0, 32'h8000_0001, "bsy_rd");
    cyc(1'b0, 1'b1, 2'd0, '0, 32'h4000_0001, "done_rd");
    idle(2);
    total++;
    if (read_data !== 32'h4000_0001) begin
      bad++;
      $display("FAIL rd_hold: got=%h want=40000001",
        read_data);
    end
    cyc(1'b0, 1'b1, 2'd0, '0, 32'h0000_0001, "done_clr");
    cyc(1'b1, 1'b0, 2'd0, 32'h8000_0001, '0, "bsy");
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL restart: got=%b want=0", error);
    end
    cyc(1'b1, 1'b1, 2'd0, 32'h8001_0002, 32'h8000_0001,
      "bsy_wr_rd");
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL bsy_start_err: got=%b want=1", error);
    end
    cyc(1'b0, 1'b1, 2'd0, '0, 32'hA000_0001, "bsy_err_rd");
    cyc(1'b0, 1'b1, 2'd0, '0, 32'h8000_0001, "no_restart");
    cyc(1'b0, 1'b1, 2'd0, '0, 32'h4000_0001, "done_again");
  endtask

  task automatic test_collision;
    cyc(1'b1, 1'b0, 2'd3, 32'h8001_0001, '0, "col");
    idle(OPC - 1);
    cyc(1'b0, 1'b1, 2'd3, '0, 32'h8001_0001, "col_busy");
    cyc(1'b0, 1'b1, 2'd3, '0, 32'h4001_0001, "col_done");
    cyc(1'b1, 1'b0, 2'd3, 32'h8001_0001, '0, "col");
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (read_data !== 32'h0) begin
      bad++;
      $display("FAIL mid_rst_rd: got=%h want=0", read_data);
    end
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_err: got=%b want=0", error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 2'd3, '0, 32'h0, "rst_ch3");
    idle(OPC + 2);
    cyc(1'b0, 1'b1, 2'd3, '0, 32'h0, "rst_ch3_idle");
    cyc(1'b0, 1'b1, 2'd1, '0, 32'h0, "rst_ch1");
    cyc(1'b0, 1'b1, 2'd0, '0, 32'h0, "rst_ch0");
  endtask

  initial begin
    test_reset();
    test_write();
    test_illegal();
    test_busy();
    test_collision();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
